pgcb_pg_rdy_seq: RTL and testbench
==================================

Name: pgcb_pg_rdy_seq

Overview:
- Power-gate entry sequencer sitting between the per-domain ClockDomainController pwrgate_ready outputs and the pgcbunit pg_rdy request/ack handshake.
- Qualifies aggregate readiness with a per-domain mask and a programmable holdoff.
- Issues and withdraws ip_pgcb_pg_rdy_req_b, and counts aborted entry attempts for debug.
- Also returns the force-clocks-on acknowledge to pgcbunit.

Parameters:
- NUM_CDC, 4, number of clock domain controllers aggregated.
- HOLDOFF_W, 4, width of the holdoff configuration and counter.
- ABORT_W, 8, width of the saturating abort counter.

Ports:
- pgcb_clk  in  1  PGCB clock.
- pgcb_rst  in  1  reset; synchronous, active-high.
- pwrgate_ready  in  NUM_CDC  per-domain ready-to-gate.
- cdc_mask  in  NUM_CDC  1 = domain participates in aggregation.
- cfg_pg_holdoff  in  HOLDOFF_W  cycles of stable readiness required before requesting.
- pwrgate_disabled  in  1  synchronized; blocks or withdraws entry.
- pmc_ip_wake  in  1  synchronized PMC wake; blocks or withdraws entry.
- pgcb_ip_pg_rdy_ack_b  in  1  pgcbunit ack, active-low.
- pgcb_ip_force_clks_on  in  1  force-clocks request from pgcbunit.
- ip_pgcb_pg_rdy_req_b  out  1  ready request to pgcbunit, active-low.
- ip_pgcb_force_clks_on_ack  out  1  force-clocks acknowledge.
- seq_state  out  3  current FSM state encoding, for VISA.
- abort_cnt  out  ABORT_W  saturating count of aborted entries.

Behaviour:
Definitions:
- all_ready = (|cdc_mask) & (&(pwrgate_ready | ~cdc_mask)).
- An all-zero cdc_mask gives all_ready=0; the block never gates.
- block = pwrgate_disabled | pmc_ip_wake.
- go = all_ready & ~block.

Reset values (pgcb_rst=1 at the clock edge):
- state=IDLE, ip_pgcb_pg_rdy_req_b=1, ip_pgcb_force_clks_on_ack=0.
- hcnt=0, abort_cnt=0.
- Reset asserted mid-sequence returns to these values on the next edge regardless of the ack level.

Outputs:
- All outputs are registered.
- ip_pgcb_pg_rdy_req_b=0 exactly when state is REQ or GATED.
- seq_state encoding: IDLE=0, HOLD=1, REQ=2, GATED=3, EXIT=4.

FSM:
- IDLE:
  - go=1 → HOLD; load hcnt=cfg_pg_holdoff, sampled only on this transition.
- HOLD:
  - If go=0 → IDLE and abort_cnt++.
  - Else if hcnt==0 → REQ.
  - Else hcnt--.
  - cfg_pg_holdoff=0 gives exactly one HOLD cycle.
  - Latency from go rising to req_b falling is cfg_pg_holdoff+2 cycles.
- REQ:
  - If go=0 → EXIT and abort_cnt++. This withdrawal has priority over an ack in the same cycle.
  - Else if ack_b==0 → GATED.
- GATED:
  - go=0 → EXIT. Not counted as an abort.
- EXIT:
  - req_b=1; wait for ack_b==1 → IDLE.
  - go re-asserting during EXIT is ignored until IDLE is reached.
  - A minimum of 1 cycle is spent in EXIT.

abort_cnt:
- Increments by 1 per abort and saturates at all-ones; it does not wrap.
- Cleared only by reset.

Force-clocks handshake:
- ip_pgcb_force_clks_on_ack <= pgcb_ip_force_clks_on, a 1-cycle registered echo in every state.
- It has no effect on the FSM.

Illegal and dynamic cases:
- An unused state encoding → IDLE on the next edge with req_b=1.
- cdc_mask changes take effect combinationally through all_ready on the next evaluation.
- No mask sampling.

Decomposition:
- Shared package pgcb_seq_pkg holds:
  - the pg_seq_state_t enum (3-bit, encodings as above);
  - localparam SEQ_STATE_W=3.
- One sub-module, pgcb_pg_holdoff_timer:
  - load/decrement down-counter of HOLDOFF_W bits with a zero flag;
  - instantiated once;
  - controlled by FSM load and decrement strobes.
- The FSM, aggregation, abort counter and force-ack echo stay in the top level.

Test Plan:
1. Reset, then NUM_CDC=4, cdc_mask=4'b1111, all ready, cfg_pg_holdoff=3, ack tied 1 → req_b falls exactly 5 cycles after ready; seq_state sequence is 0,1,1,1,1,2.
2. From REQ, drive ack_b=0 → GATED next cycle. Then drop pwrgate_ready[2] → EXIT with req_b=1; release ack_b=1 → IDLE; abort_cnt stays 0.
3. In HOLD with hcnt=2, pulse pmc_ip_wake for one cycle → IDLE, abort_cnt=1, req_b never falls. In REQ, drop ready in the same cycle ack_b falls → EXIT, abort_cnt=2.
4. cdc_mask=4'b0101, pwrgate_ready=4'b0101 → gating proceeds. cdc_mask=4'b0000 with all ready → FSM stays in IDLE indefinitely.
5. Force 300 aborts with ABORT_W=8 → abort_cnt saturates at 255. Assert pgcb_rst while in GATED with ack_b=0 → next cycle state=0, req_b=1, abort_cnt=0.
6. Toggle pgcb_ip_force_clks_on as 0,1,1,0 in any state → ip_pgcb_force_clks_on_ack is the same pattern delayed by exactly 1 cycle.

Source files
------------

// File: rtl/pgcb_seq_pkg.sv
// Shared types for the pg_rdy entry sequencer: FSM state encoding as seen on the VISA port.
package pgcb_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_REQ   = 3'd2,
        ST_GATED = 3'd3,
        ST_EXIT  = 3'd4
    } pg_seq_state_t;

endpackage

// File: rtl/pgcb_pg_holdoff_timer.sv
// Holdoff down-counter: loaded when the sequencer leaves IDLE, decremented while readiness
// stays stable, and reports zero once the programmed holdoff has elapsed.
module pgcb_pg_holdoff_timer #(
    parameter int HOLDOFF_W = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [HOLDOFF_W-1:0] load_val_i,
    output logic                 zero_o
);

    logic [HOLDOFF_W-1:0] cnt_q;
    logic [HOLDOFF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLDOFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pgcb_pg_rdy_seq.sv
// Power-gate entry sequencer: aggregates masked domain readiness, applies a holdoff, drives the
// active-low pg_rdy request to pgcbunit, counts aborted entries and echoes force-clocks-on.
module pgcb_pg_rdy_seq
    import pgcb_seq_pkg::*;
#(
    parameter int NUM_CDC   = 4,
    parameter int HOLDOFF_W = 4,
    parameter int ABORT_W   = 8
) (
    input  logic                   pgcb_clk,
    input  logic                   pgcb_rst,
    input  logic [NUM_CDC-1:0]     pwrgate_ready,
    input  logic [NUM_CDC-1:0]     cdc_mask,
    input  logic [HOLDOFF_W-1:0]   cfg_pg_holdoff,
    input  logic                   pwrgate_disabled,
    input  logic                   pmc_ip_wake,
    input  logic                   pgcb_ip_pg_rdy_ack_b,
    input  logic                   pgcb_ip_force_clks_on,
    output logic                   ip_pgcb_pg_rdy_req_b,
    output logic                   ip_pgcb_force_clks_on_ack,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [ABORT_W-1:0]     abort_cnt
);

    pg_seq_state_t      state_q;
    logic               req_b_q;
    logic               force_ack_q;
    logic [ABORT_W-1:0] abort_q;

    logic [NUM_CDC-1:0] dom_ok;
    logic               all_ready;
    logic               block;
    logic               go;
    logic               hold_zero;
    logic               hold_load;
    logic               hold_dec;

    // A masked-out domain counts as ready; an empty mask never allows gating.
    for (genvar gi = 0; gi < NUM_CDC; gi++) begin : g_dom
        assign dom_ok[gi] = pwrgate_ready[gi] | ~cdc_mask[gi];
    end

    assign all_ready = (|cdc_mask) & (&dom_ok);
    assign block     = pwrgate_disabled | pmc_ip_wake;
    assign go        = all_ready & ~block;

    assign hold_load = (state_q == ST_IDLE) && go;
    assign hold_dec  = (state_q == ST_HOLD) && go && !hold_zero;

    pgcb_pg_holdoff_timer #(
        .HOLDOFF_W (HOLDOFF_W)
    ) u_holdoff (
        .clk        (pgcb_clk),
        .srst       (pgcb_rst),
        .load_i     (hold_load),
        .dec_i      (hold_dec),
        .load_val_i (cfg_pg_holdoff),
        .zero_o     (hold_zero)
    );

    always_ff @(posedge pgcb_clk) begin
        if (pgcb_rst) begin
            state_q <= ST_IDLE;
            req_b_q <= 1'b1;
            abort_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_b_q <= 1'b1;
                    if (go) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!go) begin
                        state_q <= ST_IDLE;
                        if (abort_q != '1) abort_q <= abort_q + ABORT_W'(1);
                    end else if (hold_zero) begin
                        state_q <= ST_REQ;
                        req_b_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Losing readiness beats an ack arriving in the same cycle.
                    if (!go) begin
                        state_q <= ST_EXIT;
                        req_b_q <= 1'b1;
                        if (abort_q != '1) abort_q <= abort_q + ABORT_W'(1);
                    end else if (!pgcb_ip_pg_rdy_ack_b) begin
                        state_q <= ST_GATED;
                    end
                end
                ST_GATED: begin
                    if (!go) begin
                        state_q <= ST_EXIT;
                        req_b_q <= 1'b1;
                    end
                end
                ST_EXIT: begin
                    req_b_q <= 1'b1;
                    if (pgcb_ip_pg_rdy_ack_b) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_b_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge pgcb_clk) begin
        if (pgcb_rst) begin
            force_ack_q <= 1'b0;
        end else begin
            force_ack_q <= pgcb_ip_force_clks_on;
        end
    end

    assign ip_pgcb_pg_rdy_req_b      = req_b_q;
    assign ip_pgcb_force_clks_on_ack = force_ack_q;
    assign seq_state                 = state_q;
    assign abort_cnt                 = abort_q;

endmodule

// File: tb/tb_pgcb_pg_rdy_seq.sv
// Scenario bench for the pg_rdy entry sequencer; expected state/request pairs are queued as
// stimulus is applied and popped as the design advances.
module tb_pgcb_pg_rdy_seq;

    logic       clk;
    logic       rst;
    logic [3:0] ready;
    logic [3:0] mask;
    logic [3:0] holdoff;
    logic       disabled;
    logic       wake;
    logic       ack_b;
    logic       force_on;
    logic       req_b;
    logic       force_ack;
    logic [2:0] st;
    logic [7:0] abort_cnt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [2:0] st;
        logic       req_b;
    } exp_t;

    exp_t exp_q[$];
    logic force_q[$];

    pgcb_pg_rdy_seq #(
        .NUM_CDC   (4),
        .HOLDOFF_W (4),
        .ABORT_W   (8)
    ) dut (
        .pgcb_clk                  (clk),
        .pgcb_rst                  (rst),
        .pwrgate_ready             (ready),
        .cdc_mask                  (mask),
        .cfg_pg_holdoff            (holdoff),
        .pwrgate_disabled          (disabled),
        .pmc_ip_wake               (wake),
        .pgcb_ip_pg_rdy_ack_b      (ack_b),
        .pgcb_ip_force_clks_on     (force_on),
        .ip_pgcb_pg_rdy_req_b      (req_b),
        .ip_pgcb_force_clks_on_ack (force_ack),
        .seq_state                 (st),
        .abort_cnt                 (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares the current outputs against the oldest queued expectation, then advances.
    task automatic drain_and_tick(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (st !== e.st || req_b !== e.req_b) begin
                $display("FAIL %s[%0d]: state=%0d req_b=%0b, expected state=%0d req_b=%0b",
                         tag, i, st, req_b, e.st, e.req_b);
            end else begin
                passes++;
            end
            if (i != n - 1) tick();
        end
    endtask

    task automatic push(input logic [2:0] s, input logic r);
        exp_t e;
        e.st = s;
        e.req_b = r;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = '0; mask = '0; holdoff = '0; disabled = 1'b0;
        wake = 1'b0; ack_b = 1'b1; force_on = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (st !== 3'd0 || req_b !== 1'b1 || force_ack !== 1'b0 || abort_cnt !== 8'd0) begin
            $display("FAIL reset: state=%0d req_b=%0b fack=%0b abort=%0d, expected 0/1/0/0",
                     st, req_b, force_ack, abort_cnt);
        end else passes++;
        $display("reset done: state=%0d req_b=%0b", st, req_b);
    endtask

    task automatic test_holdoff_entry();
        mask = 4'b1111; holdoff = 4'd3; ready = 4'b1111;
        push(3'd0, 1'b1);
        for (int i = 0; i < 4; i++) push(3'd1, 1'b1);
        push(3'd2, 1'b0);
        drain_and_tick("entry_seq", 6);
        $display("entry with holdoff 3: state=%0d req_b=%0b", st, req_b);
    endtask

    task automatic test_gated_exit();
        ack_b = 1'b0;
        tick();
        push(3'd3, 1'b0);
        drain_and_tick("gated", 1);
        ready[2] = 1'b0;
        tick();
        push(3'd4, 1'b1);
        drain_and_tick("exit_wait", 1);
        tick();
        push(3'd4, 1'b1);
        drain_and_tick("exit_hold_ack", 1);
        ack_b = 1'b1;
        tick();
        push(3'd0, 1'b1);
        drain_and_tick("exit_idle", 1);
        checks++;
        if (abort_cnt !== 8'd0) $display("FAIL gated_abort: abort=%0d expected 0", abort_cnt);
        else passes++;
        $display("gated->exit->idle: state=%0d abort=%0d", st, abort_cnt);
    endtask

    task automatic test_aborts();
        ready = 4'b1111; holdoff = 4'd3;
        tick(); tick();
        push(3'd1, 1'b1);
        drain_and_tick("hold_h2", 1);
        wake = 1'b1;
        tick();
        wake = 1'b0;
        push(3'd0, 1'b1);
        drain_and_tick("wake_abort", 1);
        checks++;
        if (abort_cnt !== 8'd1) $display("FAIL wake_abort_cnt: abort=%0d expected 1", abort_cnt);
        else passes++;
        tick();
        for (int i = 0; i < 4; i++) push(3'd1, 1'b1);
        push(3'd2, 1'b0);
        drain_and_tick("reentry", 5);
        ack_b = 1'b0; ready[0] = 1'b0;
        tick();
        push(3'd4, 1'b1);
        drain_and_tick("req_withdraw", 1);
        checks++;
        if (abort_cnt !== 8'd2) $display("FAIL req_abort_cnt: abort=%0d expected 2", abort_cnt);
        else passes++;
        ready = 4'b1111;
        tick();
        push(3'd4, 1'b1);
        drain_and_tick("exit_ignores_go", 1);
        ack_b = 1'b1; ready = 4'b0000;
        tick();
        push(3'd0, 1'b1);
        drain_and_tick("exit_to_idle", 1);
        $display("abort scenarios: abort=%0d", abort_cnt);
    endtask

    task automatic test_mask();
        mask = 4'b0101; ready = 4'b0100; holdoff = 4'd0;
        tick();
        push(3'd0, 1'b1);
        drain_and_tick("mask_partial_notready", 1);
        ready = 4'b0101;
        tick();
        push(3'd1, 1'b1);
        push(3'd2, 1'b0);
        drain_and_tick("mask_0101_entry", 2);
        ack_b = 1'b0;
        tick();
        ready = 4'b0000;
        tick();
        ack_b = 1'b1;
        tick();
        push(3'd0, 1'b1);
        drain_and_tick("mask_back_idle", 1);
        mask = 4'b0000; ready = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            push(3'd0, 1'b1);
        end
        drain_and_tick("mask_empty", 10);
        $display("mask scenarios: state=%0d abort=%0d", st, abort_cnt);
    endtask

    task automatic test_saturate_and_reset();
        int exp_abort;
        exp_abort = 2;
        mask = 4'b1111; holdoff = 4'd5;
        for (int i = 0; i < 300; i++) begin
            ready = 4'b1111;
            tick();
            ready = 4'b0000;
            tick();
            exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
            if (i % 50 == 0 || i >= 250) begin
                checks++;
                if (abort_cnt !== 8'(exp_abort))
                    $display("FAIL abort_sat[%0d]: abort=%0d expected %0d", i, abort_cnt, exp_abort);
                else passes++;
            end
        end
        $display("after 300 aborts: abort=%0d", abort_cnt);
        holdoff = 4'd0; ready = 4'b1111;
        tick(); tick();
        ack_b = 1'b0;
        tick();
        push(3'd3, 1'b0);
        drain_and_tick("pre_reset_gated", 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (st !== 3'd0 || req_b !== 1'b1 || abort_cnt !== 8'd0)
            $display("FAIL gated_reset: state=%0d req_b=%0b abort=%0d expected 0/1/0", st, req_b, abort_cnt);
        else passes++;
        ack_b = 1'b1; ready = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_force_echo();
        logic [3:0] pat;
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            force_on = pat[i];
            force_q.push_back(pat[i]);
            tick();
            begin
                logic e;
                e = force_q.pop_front();
                checks++;
                if (force_ack !== e)
                    $display("FAIL force_echo[%0d]: ack=%0b expected %0b", i, force_ack, e);
                else passes++;
            end
            $display("force step %0d: req=%0b ack=%0b", i, force_on, force_ack);
        end
        force_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_holdoff_entry();
        test_gated_exit();
        test_aborts();
        test_mask();
        test_saturate_and_reset();
        test_force_echo();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
